// File: rtl/ni_packetizer_if.sv
// Core-side request/payload handshakes and router-side flit/credit signals
// of the NoC injection packetizer.
interface ni_packetizer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
);
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_dst;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  pay_valid;
  logic                  pay_ready;
  logic [DATA_WIDTH-4:0] pay_data;
  logic                  credit_in;
  logic                  flit_valid;
  logic [DATA_WIDTH-1:0] flit_out;
  logic                  busy;
  logic                  credit_err;

  modport slave (
    input  cur_addr, req_valid, req_dst, req_len, pay_valid, pay_data, credit_in,
    output req_ready, pay_ready, flit_valid, flit_out, busy, credit_err
  );

  modport master (
    output cur_addr, req_valid, req_dst, req_len, pay_valid, pay_data, credit_in,
    input  req_ready, pay_ready, flit_valid, flit_out, busy, credit_err
  );
endinterface

// File: rtl/ni_packetizer.sv
// NoC injection packetizer: turns a request plus payload words into
// header/body/tail flits, gated by credits from the router's local FIFO.
module ni_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4,
  parameter int CREDIT_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  ni_packetizer_if.slave io
);
  localparam int PAY_W  = DATA_WIDTH - 3;
  localparam int CRED_W = $clog2(CREDIT_MAX + 1);
  localparam logic [2:0] ID_HDR  = 3'b001;
  localparam logic [2:0] ID_BODY = 3'b010;
  localparam logic [2:0] ID_TAIL = 3'b100;

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic                  credit_err_q, credit_err_d;
  logic                  flit_valid_q, flit_valid_d;
  logic [DATA_WIDTH-1:0] flit_q, flit_d;
  logic                  has_credit;
  logic                  emit;
  logic                  req_ready;
  logic                  pay_ready;

  function automatic logic [DATA_WIDTH-1:0] make_header(
    input logic [ADDR_WIDTH-1:0] dst,
    input logic [ADDR_WIDTH-1:0] src,
    input logic [LEN_WIDTH-1:0]  len
  );
    logic [DATA_WIDTH-1:0] h;
    h = '0;
    h[DATA_WIDTH-1 -: 3]                         = ID_HDR;
    h[DATA_WIDTH-4 -: ADDR_WIDTH]                = dst;
    h[DATA_WIDTH-4-ADDR_WIDTH -: ADDR_WIDTH]     = src;
    h[DATA_WIDTH-4-2*ADDR_WIDTH -: LEN_WIDTH]    = len;
    return h;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_payload(
    input logic [2:0]       id,
    input logic [PAY_W-1:0] data
  );
    return {id, data};
  endfunction

  // Credits are judged on the registered count only, so a credit arriving
  // this cycle enables an emission from the next cycle onward.
  assign has_credit = (credits_q != '0);

  always_comb begin
    state_d      = state_q;
    dst_d        = dst_q;
    len_d        = len_q;
    remaining_d  = remaining_q;
    flit_d       = flit_q;
    emit         = 1'b0;
    req_ready    = 1'b0;
    pay_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (io.req_valid) begin
          dst_d   = io.req_dst;
          len_d   = (io.req_len == '0) ? LEN_WIDTH'(1) : io.req_len;
          state_d = HDR;
        end
      end
      HDR: begin
        if (has_credit) begin
          emit        = 1'b1;
          flit_d      = make_header(dst_q, io.cur_addr, len_q);
          remaining_d = len_q;
          state_d     = PAY;
        end
      end
      PAY: begin
        pay_ready = has_credit;
        if (io.pay_valid && has_credit) begin
          emit        = 1'b1;
          remaining_d = remaining_q - LEN_WIDTH'(1);
          if (remaining_q > LEN_WIDTH'(1)) begin
            flit_d = make_payload(ID_BODY, io.pay_data);
          end else begin
            flit_d  = make_payload(ID_TAIL, io.pay_data);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    flit_valid_d = emit;
  end

  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    case ({emit, io.credit_in})
      2'b10: credits_d = credits_q - CRED_W'(1);
      2'b01: begin
        if (credits_q == CRED_W'(CREDIT_MAX)) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + CRED_W'(1);
        end
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dst_q        <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
      credits_q    <= CRED_W'(CREDIT_MAX);
      credit_err_q <= 1'b0;
      flit_valid_q <= 1'b0;
      flit_q       <= '0;
    end else begin
      state_q      <= state_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      remaining_q  <= remaining_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      flit_valid_q <= flit_valid_d;
      flit_q       <= flit_d;
    end
  end

  assign io.req_ready  = req_ready;
  assign io.pay_ready  = pay_ready;
  assign io.flit_valid = flit_valid_q;
  assign io.flit_out   = flit_q;
  assign io.busy       = (state_q != IDLE);
  assign io.credit_err = credit_err_q;
endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: flit formats, credit stalls and
// pass-through, credit overflow and asynchronous reset mid-packet.
module tb_ni_packetizer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ni_packetizer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .LEN_WIDTH(4)) io ();

  ni_packetizer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .LEN_WIDTH(4), .CREDIT_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (io.req_ready !== 1'b1 || io.busy !== 1'b0 || io.pay_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl req_ready=%b busy=%b pay_ready=%b, want 1 0 0",
               io.req_ready, io.busy, io.pay_ready);
    end
    checks++;
    if (io.flit_valid !== 1'b0 || io.flit_out !== 32'h0 || io.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data flit_valid=%b flit_out=%h credit_err=%b, want 0 00000000 0",
               io.flit_valid, io.flit_out, io.credit_err);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp [4];
    exp = '{32'h34A60000, 32'h40000001, 32'h40000002, 32'h80000003};
    io.cur_addr = 4'h5; io.req_dst = 4'hA; io.req_len = 4'd3; io.req_valid = 1'b1;
    io.pay_valid = 1'b1; io.pay_data = 29'd1;
    tick();
    io.req_valid = 1'b0;
    checks++;
    if (io.busy !== 1'b1 || io.flit_valid !== 1'b0 || io.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_hdr_wait busy=%b flit_valid=%b req_ready=%b, want 1 0 0",
               io.busy, io.flit_valid, io.req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (io.flit_valid !== 1'b1 || io.flit_out !== exp[i]) begin
        errors++;
        $display("FAIL basic_flit%0d valid=%b data=%h, want 1 %h", i, io.flit_valid, io.flit_out, exp[i]);
      end
      io.pay_data = 29'(i + 1);
    end
    checks++;
    if (io.busy !== 1'b0 || io.req_ready !== 1'b1 || io.pay_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_end busy=%b req_ready=%b pay_ready=%b, want 0 1 0",
               io.busy, io.req_ready, io.pay_ready);
    end
    io.pay_valid = 1'b0;
    tick();
    checks++;
    if (io.flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_no_repeat flit_valid=%b, want 0", io.flit_valid);
    end
    // Counter should be empty now: four returns must not overflow it.
    io.credit_in = 1'b1;
    repeat (4) tick();
    io.credit_in = 1'b0;
    tick();
    checks++;
    if (io.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_credits_zero credit_err=%b, want 0", io.credit_err);
    end
  endtask

  task automatic test_len0_local();
    io.cur_addr = 4'h3; io.req_dst = 4'h3; io.req_len = 4'd0; io.req_valid = 1'b1;
    io.pay_valid = 1'b1; io.pay_data = 29'h00ABCDE;
    tick();
    io.req_valid = 1'b0;
    tick();
    checks++;
    if (io.flit_valid !== 1'b1 || io.flit_out !== 32'h26620000) begin
      errors++;
      $display("FAIL len0_hdr valid=%b data=%h, want 1 26620000", io.flit_valid, io.flit_out);
    end
    tick();
    checks++;
    if (io.flit_valid !== 1'b1 || io.flit_out !== 32'h800ABCDE || io.busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_tail valid=%b data=%h busy=%b, want 1 800abcde 0",
               io.flit_valid, io.flit_out, io.busy);
    end
    io.pay_valid = 1'b0;
    tick();
    checks++;
    if (io.flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL len0_extra flit_valid=%b, want 0", io.flit_valid);
    end
    io.credit_in = 1'b1;
    repeat (2) tick();
    io.credit_in = 1'b0;
    checks++;
    if (io.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL len0_credits credit_err=%b, want 0", io.credit_err);
    end
  endtask

  task automatic test_credit_stall();
    int          n;
    logic [31:0] last;
    io.cur_addr = 4'h5; io.req_dst = 4'h1; io.req_len = 4'd6; io.req_valid = 1'b1;
    io.pay_valid = 1'b1; io.pay_data = 29'h55;
    tick();
    io.req_valid = 1'b0;
    n = 0;
    repeat (10) begin
      tick();
      if (io.flit_valid === 1'b1) n++;
    end
    checks++;
    if (n != 4 || io.flit_valid !== 1'b0 || io.pay_ready !== 1'b0 || io.busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_count flits=%0d flit_valid=%b pay_ready=%b busy=%b, want 4 0 0 1",
               n, io.flit_valid, io.pay_ready, io.busy);
    end
    io.credit_in = 1'b1;
    tick();
    io.credit_in = 1'b0;
    checks++;
    if (io.flit_valid !== 1'b0 || io.pay_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_credit_arrive flit_valid=%b pay_ready=%b, want 0 1", io.flit_valid, io.pay_ready);
    end
    tick();
    checks++;
    if (io.flit_valid !== 1'b1 || io.flit_out !== 32'h40000055) begin
      errors++;
      $display("FAIL stall_release valid=%b data=%h, want 1 40000055", io.flit_valid, io.flit_out);
    end
    tick();
    checks++;
    if (io.flit_valid !== 1'b0 || io.pay_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_only_one flit_valid=%b pay_ready=%b, want 0 0", io.flit_valid, io.pay_ready);
    end
    io.credit_in = 1'b1;
    n = 0;
    last = '0;
    repeat (6) begin
      tick();
      if (io.flit_valid === 1'b1) begin
        n++;
        last = io.flit_out;
      end
    end
    io.credit_in = 1'b0;
    io.pay_valid = 1'b0;
    checks++;
    if (n != 2 || last !== 32'h80000055 || io.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_finish flits=%0d last=%h busy=%b, want 2 80000055 0", n, last, io.busy);
    end
    tick();
    checks++;
    if (io.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_credit_err credit_err=%b, want 0", io.credit_err);
    end
  endtask

  task automatic test_credit_passthrough();
    logic [31:0] exp;
    io.cur_addr = 4'h5; io.req_dst = 4'hA; io.req_len = 4'd8; io.req_valid = 1'b1;
    io.pay_valid = 1'b1; io.pay_data = 29'd1;
    tick();
    io.req_valid = 1'b0;
    io.credit_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp = (i == 0) ? 32'h34B00000 : (i == 8) ? 32'h80000008 : (32'h40000000 | 32'(i));
      checks++;
      if (io.flit_valid !== 1'b1 || io.flit_out !== exp || (i < 8 && io.pay_ready !== 1'b1)) begin
        errors++;
        $display("FAIL pass_flit%0d valid=%b data=%h pay_ready=%b, want 1 %h 1",
                 i, io.flit_valid, io.flit_out, io.pay_ready, exp);
      end
      io.pay_data = 29'(i + 1);
    end
    io.credit_in = 1'b0;
    io.pay_valid = 1'b0;
    tick();
    checks++;
    if (io.credit_err !== 1'b0 || io.flit_valid !== 1'b0) begin
      errors++;
      $display("FAIL pass_end credit_err=%b flit_valid=%b, want 0 0", io.credit_err, io.flit_valid);
    end
  endtask

  task automatic test_credit_overflow();
    io.credit_in = 1'b1;
    tick();
    io.credit_in = 1'b0;
    checks++;
    if (io.credit_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set credit_err=%b, want 1", io.credit_err);
    end
    repeat (3) tick();
    checks++;
    if (io.credit_err !== 1'b1 || io.busy !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky credit_err=%b busy=%b, want 1 0", io.credit_err, io.busy);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp [4];
    int          n;
    exp = '{32'h34A60000, 32'h40000001, 32'h40000002, 32'h80000003};
    io.cur_addr = 4'h5; io.req_dst = 4'h7; io.req_len = 4'd10; io.req_valid = 1'b1;
    io.pay_valid = 1'b1; io.pay_data = 29'h1234;
    tick();
    io.req_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (io.flit_valid !== 1'b1 || io.flit_out !== 32'h40001234) begin
      errors++;
      $display("FAIL areset_mid valid=%b data=%h, want 1 40001234", io.flit_valid, io.flit_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (io.flit_valid !== 1'b0 || io.flit_out !== 32'h0 || io.busy !== 1'b0 ||
        io.req_ready !== 1'b1 || io.pay_ready !== 1'b0 || io.credit_err !== 1'b0) begin
      errors++;
      $display("FAIL areset_now valid=%b data=%h busy=%b req_ready=%b pay_ready=%b err=%b, want 0 00000000 0 1 0 0",
               io.flit_valid, io.flit_out, io.busy, io.req_ready, io.pay_ready, io.credit_err);
    end
    @(negedge clk);
    rst = 1'b0;
    io.req_dst = 4'hA; io.req_len = 4'd3; io.req_valid = 1'b1; io.pay_data = 29'd1;
    tick();
    io.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (io.flit_valid !== 1'b1 || io.flit_out !== exp[i]) begin
        errors++;
        $display("FAIL areset_pkt%0d valid=%b data=%h, want 1 %h", i, io.flit_valid, io.flit_out, exp[i]);
      end
      io.pay_data = 29'(i + 1);
    end
    io.pay_valid = 1'b0;
    // Exactly four returns refill the counter; a fifth overflows it.
    n = 0;
    io.credit_in = 1'b1;
    repeat (4) tick();
    if (io.credit_err === 1'b1) n++;
    tick();
    io.credit_in = 1'b0;
    checks++;
    if (n != 0 || io.credit_err !== 1'b1) begin
      errors++;
      $display("FAIL areset_credits err_after4=%0d err_after5=%b, want 0 1", n, io.credit_err);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    io.cur_addr = '0; io.req_valid = 1'b0; io.req_dst = '0; io.req_len = '0;
    io.pay_valid = 1'b0; io.pay_data = '0; io.credit_in = 1'b0;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_len0_local();
    test_credit_stall();
    test_credit_passthrough();
    test_credit_overflow();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
